// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - NUM_PORTS x NUM_PORTS round-robin switch allocator with optional wormhole lock
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int DPORT_W   = $clog2(NUM_PORTS),
  parameter bit LOCK_EN   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_req,
  input  logic [NUM_PORTS*DPORT_W-1:0]   in_dport,
  input  logic [NUM_PORTS-1:0]           in_tail,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           in_grant,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*DPORT_W-1:0]   out_sel,
  output logic                           err
);

  typedef enum logic {ST_IDLE, ST_LOCKED} out_state_t;

  out_state_t             state_q [NUM_PORTS];
  out_state_t             state_d [NUM_PORTS];
  logic [DPORT_W-1:0]     ptr_q   [NUM_PORTS];
  logic [DPORT_W-1:0]     ptr_d   [NUM_PORTS];
  logic [DPORT_W-1:0]     owner_q [NUM_PORTS];
  logic [DPORT_W-1:0]     owner_d [NUM_PORTS];
  logic                   err_q, err_d;

  logic [DPORT_W-1:0]     dport    [NUM_PORTS];
  logic [NUM_PORTS-1:0]   dport_ok;
  logic [NUM_PORTS-1:0]   cand     [NUM_PORTS];
  logic                   found    [NUM_PORTS];
  logic [DPORT_W-1:0]     win      [NUM_PORTS];
  logic [NUM_PORTS-1:0]   valid_c;
  logic [NUM_PORTS-1:0]   grant_c;
  logic [NUM_PORTS*DPORT_W-1:0] sel_c;

  always_comb begin : decode
    for (int i = 0; i < NUM_PORTS; i++) begin
      dport[i]    = in_dport[i*DPORT_W +: DPORT_W];
      dport_ok[i] = ({1'b0, dport[i]} < (DPORT_W+1)'(NUM_PORTS));
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = in_req[i] & dport_ok[i] & (dport[i] == DPORT_W'(o));
      end
    end
  end

  // First candidate at or after ptr, wrapping modulo NUM_PORTS.
  always_comb begin : rr_pick
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      found[o] = 1'b0;
      win[o]   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(ptr_q[o]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found[o] && cand[o][idx]) begin
          found[o] = 1'b1;
          win[o]   = DPORT_W'(idx);
        end
      end
    end
  end

  always_comb begin : next_state
    err_d   = err_q;
    valid_c = '0;
    sel_c   = '0;
    grant_c = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      owner_d[o] = owner_q[o];
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_req[i] && !dport_ok[i]) err_d = 1'b1;
    end

    for (int o = 0; o < NUM_PORTS; o++) begin
      // A lock owner steering elsewhere mid-packet is a protocol error; the lock stays.
      if (state_q[o] == ST_LOCKED && in_req[owner_q[o]] && dport[owner_q[o]] != DPORT_W'(o))
        err_d = 1'b1;

      if (out_ready[o]) begin
        if (state_q[o] == ST_IDLE) begin
          if (found[o]) begin
            valid_c[o]                   = 1'b1;
            sel_c[o*DPORT_W +: DPORT_W]  = win[o];
            ptr_d[o] = (win[o] == DPORT_W'(NUM_PORTS-1)) ? '0 : win[o] + 1'b1;
            if (LOCK_EN && !in_tail[win[o]]) begin
              state_d[o] = ST_LOCKED;
              owner_d[o] = win[o];
            end
          end
        end else if (cand[o][owner_q[o]]) begin
          valid_c[o]                  = 1'b1;
          sel_c[o*DPORT_W +: DPORT_W] = owner_q[o];
          if (in_tail[owner_q[o]]) state_d[o] = ST_IDLE;
        end
      end
    end

    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (valid_c[o] && sel_c[o*DPORT_W +: DPORT_W] == DPORT_W'(i)) grant_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= ST_IDLE;
        ptr_q[o]   <= '0;
        owner_q[o] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        owner_q[o] <= owner_d[o];
      end
      err_q <= err_d;
    end
  end

  assign in_grant  = rst ? grant_c : '0;
  assign out_valid = rst ? valid_c : '0;
  assign out_sel   = rst ? sel_c   : '0;
  assign err       = err_q;

endmodule
